// File: rtl/if_id_pkg.sv
// Shared definitions for the IF/ID fetch queue: default data width, the bubble
// instruction presented to decode, and the queue entry layout.
package if_id_pkg;

    localparam int unsigned IF_ID_DATA_W = 32;

    // MOV r0,r0: decode sees this whenever the queue has no valid head.
    localparam logic [31:0] IF_ID_NOP = 32'hE1A00000;

    typedef struct packed {
        logic [IF_ID_DATA_W-1:0] pc;
        logic [IF_ID_DATA_W-1:0] instr;
    } if_id_entry_t;

endpackage : if_id_pkg

// File: rtl/if_id_fetch_queue_if.sv
// IF/ID queue handshake bundle.
//   fetch side : In_Valid, PC_in, Instruction_in -> In_Ready
//   decode side: Out_Valid, PC_out, Instruction_out, Freeze
//   control    : Branch_Taken (flush)
// slave = the queue, master = the surrounding pipeline.
interface if_id_fetch_queue_if
    import if_id_pkg::*;
#(
    parameter int unsigned DATA_W = IF_ID_DATA_W
);
    logic              Branch_Taken;
    logic              In_Valid;
    logic [DATA_W-1:0] PC_in;
    logic [DATA_W-1:0] Instruction_in;
    logic              In_Ready;
    logic              Freeze;
    logic              Out_Valid;
    logic [DATA_W-1:0] PC_out;
    logic [DATA_W-1:0] Instruction_out;

    modport slave (
        input  Branch_Taken, In_Valid, PC_in, Instruction_in, Freeze,
        output In_Ready, Out_Valid, PC_out, Instruction_out
    );

    modport master (
        output Branch_Taken, In_Valid, PC_in, Instruction_in, Freeze,
        input  In_Ready, Out_Valid, PC_out, Instruction_out
    );
endinterface : if_id_fetch_queue_if

// File: rtl/if_id_queue_mem.sv
// Storage array for the fetch queue: DEPTH x W flops, one synchronous write
// port and one combinational read port. No reset; validity is tracked by the
// owner's count.
//   clk      : rising-edge clock
//   wr_en    : write strobe
//   wr_addr  : write slot
//   wr_data  : entry to store
//   rd_addr  : read slot
//   rd_data  : entry at rd_addr (combinational)
module if_id_queue_mem #(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned W     = 64
) (
    input  logic                     clk,
    input  logic                     wr_en,
    input  logic [$clog2(DEPTH)-1:0] wr_addr,
    input  logic [W-1:0]             wr_data,
    input  logic [$clog2(DEPTH)-1:0] rd_addr,
    output logic [W-1:0]             rd_data
);
    logic [W-1:0] mem [DEPTH];

    // Write port.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule : if_id_queue_mem

// File: rtl/if_id_fetch_queue.sv
// Decoupling queue between fetch and decode. Buffers up to DEPTH {PC, instr}
// pairs, backpressures fetch via In_Ready, holds its head while decode asserts
// Freeze, and flushes all entries in one cycle on Branch_Taken.
// All bus outputs are registered: the head is computed from next-state
// pointers so a pushed entry is visible one cycle later.
//   clk, rst : clock, asynchronous active-low reset
//   bus      : if_id_fetch_queue_if slave (handshake + head outputs)
//   Stall_Count, Flush_Count : saturating perf counters, only when
//                              IF_ID_PERF_CNT_EN is defined
module if_id_fetch_queue
    import if_id_pkg::*;
#(
    parameter int unsigned DEPTH  = 2,
    parameter int unsigned DATA_W = IF_ID_DATA_W
) (
    input  logic                clk,
    input  logic                rst,
`ifdef IF_ID_PERF_CNT_EN
    output logic [31:0]         Stall_Count,
    output logic [31:0]         Flush_Count,
`endif
    if_id_fetch_queue_if.slave  bus
);
    localparam int unsigned PTR_W   = $clog2(DEPTH);
    localparam int unsigned CNT_W   = $clog2(DEPTH) + 1;
    localparam int unsigned ENTRY_W = 2 * DATA_W;

    logic [PTR_W-1:0]   rd_ptr, rd_ptr_next;
    logic [PTR_W-1:0]   wr_ptr, wr_ptr_next;
    logic [CNT_W-1:0]   count, count_next;
    logic               out_valid_q, in_ready_q;
    logic [DATA_W-1:0]  pc_q, instr_q;

    logic               push, pop, mem_wr_en, head_bypass;
    logic [ENTRY_W-1:0] wr_data, rd_data, head_next;

    assign push    = bus.In_Valid & in_ready_q;
    assign pop     = out_valid_q & ~bus.Freeze;
    assign wr_data = {bus.PC_in, bus.Instruction_in};

    // Next-state pointers and count; flush overrides push and pop.
    always_comb begin
        rd_ptr_next = rd_ptr;
        wr_ptr_next = wr_ptr;
        count_next  = count;
        mem_wr_en   = 1'b0;
        if (bus.Branch_Taken) begin
            rd_ptr_next = wr_ptr;
            count_next  = '0;
        end else begin
            if (push) begin
                wr_ptr_next = PTR_W'(wr_ptr + PTR_W'(1));
                mem_wr_en   = 1'b1;
            end
            if (pop) begin
                rd_ptr_next = PTR_W'(rd_ptr + PTR_W'(1));
            end
            case ({push, pop})
                2'b10:   count_next = CNT_W'(count + CNT_W'(1));
                2'b01:   count_next = CNT_W'(count - CNT_W'(1));
                default: count_next = count;
            endcase
        end
    end

    if_id_queue_mem #(
        .DEPTH (DEPTH),
        .W     (ENTRY_W)
    ) u_mem (
        .clk     (clk),
        .wr_en   (mem_wr_en),
        .wr_addr (wr_ptr),
        .wr_data (wr_data),
        .rd_addr (rd_ptr_next),
        .rd_data (rd_data)
    );

    // The slot being written this cycle becomes the new head when the queue is
    // empty (no pop) or drains to it (count 1 with pop): forward the input.
    always_comb begin
        head_bypass = push & ~bus.Branch_Taken & (wr_ptr == rd_ptr_next);
        head_next   = head_bypass ? wr_data : rd_data;
    end

    // State and registered outputs; an empty queue presents a NOP bubble.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            count       <= '0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            pc_q        <= '0;
            instr_q     <= DATA_W'(IF_ID_NOP);
        end else begin
            rd_ptr      <= rd_ptr_next;
            wr_ptr      <= wr_ptr_next;
            count       <= count_next;
            out_valid_q <= (count_next != '0);
            in_ready_q  <= (count_next != CNT_W'(DEPTH));
            if (count_next != '0) begin
                pc_q    <= head_next[ENTRY_W-1:DATA_W];
                instr_q <= head_next[DATA_W-1:0];
            end else begin
                pc_q    <= '0;
                instr_q <= DATA_W'(IF_ID_NOP);
            end
        end
    end

    assign bus.Out_Valid       = out_valid_q;
    assign bus.In_Ready        = in_ready_q;
    assign bus.PC_out          = pc_q;
    assign bus.Instruction_out = instr_q;

`ifdef IF_ID_PERF_CNT_EN
    // Saturating counters: blocked fetch cycles and flush cycles.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            Stall_Count <= '0;
            Flush_Count <= '0;
        end else begin
            if (bus.In_Valid && !in_ready_q && (Stall_Count != 32'hFFFF_FFFF)) begin
                Stall_Count <= Stall_Count + 32'd1;
            end
            if (bus.Branch_Taken && (Flush_Count != 32'hFFFF_FFFF)) begin
                Flush_Count <= Flush_Count + 32'd1;
            end
        end
    end
`endif

endmodule : if_id_fetch_queue

// File: tb/tb_if_id_fetch_queue.sv
// Directed bench for if_id_fetch_queue with a queue-based reference model
// checked every cycle plus literal expectations for each scenario.
module tb_if_id_fetch_queue;
    import if_id_pkg::*;

    localparam int unsigned DEPTH  = 2;
    localparam int unsigned DATA_W = 32;

    logic clk;
    logic rst;

    if_id_fetch_queue_if #(.DATA_W(DATA_W)) bus ();

`ifdef IF_ID_PERF_CNT_EN
    logic [31:0] stall_count;
    logic [31:0] flush_count;
`endif

    if_id_fetch_queue #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
`ifdef IF_ID_PERF_CNT_EN
        .Stall_Count (stall_count),
        .Flush_Count (flush_count),
`endif
        .bus         (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a plain FIFO of entries, updated on each rising edge.
    if_id_entry_t mq[$];

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            mq.delete();
        end else begin
            bit m_push, m_pop;
            m_push = bus.In_Valid && (mq.size() < DEPTH);
            m_pop  = (mq.size() > 0) && !bus.Freeze;
            if (bus.Branch_Taken) begin
                mq.delete();
            end else begin
                if (m_pop)  void'(mq.pop_front());
                if (m_push) mq.push_back('{pc: bus.PC_in, instr: bus.Instruction_in});
            end
        end
    end

    // Every-cycle comparison against the model, away from the rising edge.
    bit model_on = 1'b0;
    always @(negedge clk) begin
        if (model_on) begin
            chk("m_valid", 32'(bus.Out_Valid), 32'(mq.size() != 0));
            chk("m_ready", 32'(bus.In_Ready),  32'(mq.size() != DEPTH));
            chk("m_pc",    bus.PC_out,          (mq.size() != 0) ? mq[0].pc : 32'h0);
            chk("m_instr", bus.Instruction_out, (mq.size() != 0) ? mq[0].instr : IF_ID_NOP);
        end
    end

    logic [31:0] rec[$];
    bit          pend;

    initial begin
        rst                = 1'b1;
        bus.Branch_Taken   = 1'b0;
        bus.In_Valid       = 1'b1;
        bus.PC_in          = 32'h55;
        bus.Instruction_in = 32'h1234_5678;
        bus.Freeze         = 1'b0;
        #1 rst = 1'b0;

        // 1: reset holds the queue empty despite In_Valid.
        repeat (3) @(negedge clk);
        model_on = 1'b1;
        chk("rst_valid", 32'(bus.Out_Valid), 32'd0);
        chk("rst_ready", 32'(bus.In_Ready), 32'd1);
        chk("rst_instr", bus.Instruction_out, 32'hE1A00000);
        chk("rst_pc",    bus.PC_out, 32'h0);
        bus.In_Valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        chk("post_rst_valid", 32'(bus.Out_Valid), 32'd0);

        // 2: single push, visible next cycle, popped the cycle after.
        bus.In_Valid = 1'b1; bus.PC_in = 32'd1; bus.Instruction_in = 32'hE3A01005;
        @(negedge clk);
        bus.In_Valid = 1'b0;
        chk("t2_valid", 32'(bus.Out_Valid), 32'd1);
        chk("t2_pc",    bus.PC_out, 32'd1);
        chk("t2_instr", bus.Instruction_out, 32'hE3A01005);
        @(negedge clk);
        chk("t2_pop_valid", 32'(bus.Out_Valid), 32'd0);
        chk("t2_pop_instr", bus.Instruction_out, 32'hE1A00000);

        // 3: freeze fills the queue; release drains 1,2,3 in order.
        bus.Freeze = 1'b1;
        for (int i = 1; i <= 2; i++) begin
            bus.In_Valid = 1'b1; bus.PC_in = 32'(i); bus.Instruction_in = 32'(32'hA000 + i);
            @(negedge clk);
        end
        chk("t3_full_ready", 32'(bus.In_Ready), 32'd0);
        bus.PC_in = 32'd3; bus.Instruction_in = 32'hA003;
        @(negedge clk);
        chk("t3_frozen_pc", bus.PC_out, 32'd1);
        bus.Freeze = 1'b0;
        pend = 1'b0;
        rec.delete();
        for (int i = 0; i < 8; i++) begin
            if (bus.Out_Valid && !bus.Freeze) rec.push_back(bus.PC_out);
            if (bus.In_Valid && bus.In_Ready) pend = 1'b1;
            @(negedge clk);
            if (pend) begin bus.In_Valid = 1'b0; pend = 1'b0; end
        end
        chk("t3_count", 32'(rec.size()), 32'd3);
        for (int i = 0; i < 3; i++) begin
            chk("t3_order", (i < rec.size()) ? rec[i] : 32'hDEAD, 32'(i + 1));
        end

        // 4: flush on a full queue drops the same-cycle push.
        bus.Freeze = 1'b1;
        for (int i = 7; i <= 8; i++) begin
            bus.In_Valid = 1'b1; bus.PC_in = 32'(i); bus.Instruction_in = 32'(32'hB000 + i);
            @(negedge clk);
        end
        chk("t4_full_ready", 32'(bus.In_Ready), 32'd0);
        bus.Branch_Taken = 1'b1; bus.PC_in = 32'd9; bus.Instruction_in = 32'hB009;
        @(negedge clk);
        bus.Branch_Taken = 1'b0;
        chk("t4_flush_valid", 32'(bus.Out_Valid), 32'd0);
        chk("t4_flush_ready", 32'(bus.In_Ready), 32'd1);
        chk("t4_flush_instr", bus.Instruction_out, 32'hE1A00000);
        bus.PC_in = 32'd20; bus.Instruction_in = 32'hB020;
        @(negedge clk);
        bus.In_Valid = 1'b0;
        chk("t4_next_pc",    bus.PC_out, 32'd20);
        chk("t4_next_instr", bus.Instruction_out, 32'hB020);
        bus.Freeze = 1'b0;
        @(negedge clk);
        chk("t4_drained", 32'(bus.Out_Valid), 32'd0);

        // 5: stream 100 entries at one per cycle through wrapping pointers.
        for (int i = 0; i < 100; i++) begin
            bus.In_Valid = 1'b1; bus.PC_in = 32'(100 + i); bus.Instruction_in = 32'(32'hC000 + i);
            @(negedge clk);
            chk("t5_pc",    bus.PC_out, 32'(100 + i));
            chk("t5_ready", 32'(bus.In_Ready), 32'd1);
        end
        bus.In_Valid = 1'b0;
        @(negedge clk);
        chk("t5_end_valid", 32'(bus.Out_Valid), 32'd0);

`ifdef IF_ID_PERF_CNT_EN
        // 6: five blocked push cycles and two flushes after a fresh reset.
        #2 rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        bus.Freeze = 1'b1;
        for (int i = 0; i < 7; i++) begin
            bus.In_Valid = 1'b1; bus.PC_in = 32'(40 + i); bus.Instruction_in = 32'hD000;
            @(negedge clk);
        end
        bus.In_Valid = 1'b0;
        bus.Branch_Taken = 1'b1;
        repeat (2) @(negedge clk);
        bus.Branch_Taken = 1'b0;
        bus.Freeze = 1'b0;
        @(negedge clk);
        chk("t6_stall", stall_count, 32'd5);
        chk("t6_flush", flush_count, 32'd2);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_if_id_fetch_queue
